// File: rtl/apu_frame_counter.sv
// APU frame sequencer: counts CPU ticks, emits quarter/half-frame strobes and the
// frame IRQ, and applies $4017 mode writes after a short tick delay.
module apu_frame_counter #(
    parameter int STEP1    = 7457,
    parameter int STEP2    = 14913,
    parameter int STEP3    = 22371,
    parameter int STEP4    = 29829,
    parameter int STEP5    = 37281,
    parameter int WR_DELAY = 3
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       cpu_ce,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_data,
    input  logic       status_rd,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode,
    output logic       irq_inhibit
);

    localparam int DW = $clog2(WR_DELAY + 1);

    localparam logic [15:0] S1   = 16'(STEP1);
    localparam logic [15:0] S2   = 16'(STEP2);
    localparam logic [15:0] S3   = 16'(STEP3);
    localparam logic [15:0] S4   = 16'(STEP4);
    localparam logic [15:0] S4M1 = 16'(STEP4 - 1);
    localparam logic [15:0] S5   = 16'(STEP5);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } wr_state_t;

    wr_state_t         state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic              mode_q, mode_d;
    logic              pend_mode_q, pend_mode_d;
    logic              irq_inhibit_q, irq_inhibit_d;
    logic              frame_irq_q, frame_irq_d;
    logic              qf_q, qf_d;
    logic              hf_q, hf_d;

    logic [15:0]       last_count;
    logic              hit_q;
    logic              hit_qh;
    logic              hit_irq;
    logic              reload;
    logic              irq_set;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            dly_q         <= '0;
            mode_q        <= 1'b0;
            pend_mode_q   <= 1'b0;
            irq_inhibit_q <= 1'b0;
            frame_irq_q   <= 1'b0;
            qf_q          <= 1'b0;
            hf_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            dly_q         <= dly_d;
            mode_q        <= mode_d;
            pend_mode_q   <= pend_mode_d;
            irq_inhibit_q <= irq_inhibit_d;
            frame_irq_q   <= frame_irq_d;
            qf_q          <= qf_d;
            hf_q          <= hf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        dly_d         = dly_q;
        mode_d        = mode_q;
        pend_mode_d   = pend_mode_q;
        irq_inhibit_d = irq_inhibit_q;
        frame_irq_d   = frame_irq_q;
        qf_d          = 1'b0;
        hf_d          = 1'b0;
        irq_set       = 1'b0;

        last_count = mode_q ? S5 : S4;
        hit_q      = (count_q == S1) || (count_q == S3);
        hit_qh     = (count_q == S2) || (count_q == last_count);
        hit_irq    = !mode_q && !irq_inhibit_q && ((count_q == S4M1) || (count_q == S4));
        // A write landing on the expiring tick restarts the delay instead of applying.
        reload     = cpu_ce && (state_q == ST_PENDING) && (dly_q == DW'(1)) && !cfg_wr;

        if (cpu_ce) begin
            if (reload && pend_mode_q) begin
                qf_d = 1'b1;
                hf_d = 1'b1;
            end else begin
                qf_d    = hit_q || hit_qh;
                hf_d    = hit_qh;
                irq_set = hit_irq;
            end

            if (reload) begin
                count_d = '0;
                mode_d  = pend_mode_q;
                state_d = ST_IDLE;
                dly_d   = '0;
            end else begin
                count_d = (count_q == last_count) ? 16'd0 : count_q + 16'd1;
                if (state_q == ST_PENDING) begin
                    dly_d = dly_q - DW'(1);
                end
            end
        end

        // Priority: read clear < tick set < inhibit write clear.
        if (status_rd) begin
            frame_irq_d = 1'b0;
        end
        if (irq_set) begin
            frame_irq_d = 1'b1;
        end

        if (cfg_wr) begin
            irq_inhibit_d = cfg_data[6];
            if (cfg_data[6]) begin
                frame_irq_d = 1'b0;
            end
            pend_mode_d = cfg_data[7];
            dly_d       = DW'(WR_DELAY);
            state_d     = ST_PENDING;
        end
    end

    assign quarter_frame = qf_q;
    assign half_frame    = hf_q;
    assign frame_irq     = frame_irq_q;
    assign mode          = mode_q;
    assign irq_inhibit   = irq_inhibit_q;

endmodule
